// File: rtl/wcb_pkg.sv
// Shared types, geometry constants and helpers for the line write-combining buffer.
// Optional store-to-load forwarding is enabled by defining WCB_FORWARD_EN.
package wcb_pkg;

   localparam int s_offset  = 5;
   localparam int s_mask    = 2**s_offset;
   localparam int s_line    = 8*s_mask;
   localparam int num_words = s_line/32;
   localparam int lane_bits = s_offset-2;
   localparam int tag_bits  = 32-s_offset;

   typedef enum logic [1:0] {IDLE, FLUSH, READ} state_t;

   typedef logic [s_line-1:0] line_t;
   typedef logic [s_mask-1:0] mask_t;

   function automatic logic [31:0] line_of(input logic [31:0] addr);
      return {addr[31:s_offset], {s_offset{1'b0}}};
   endfunction

   // Byte-valid mask to a bit mask, used to merge bytes into the buffer.
   function automatic line_t expand_mask(input mask_t m);
      line_t bits;
      for (int i = 0; i < s_mask; i++) begin
         bits[8*i +: 8] = {8{m[i]}};
      end
      return bits;
   endfunction

endpackage

// File: rtl/word_lane_mux.sv
// Word/line lane steering: replicate a word across lanes, position its byte
// enables, and extract one 32-bit lane from a line.
module word_lane_mux
   import wcb_pkg::*;
(
   input  logic [31:0]          word_data,
   input  logic [3:0]           byte_enable,
   input  logic [lane_bits-1:0] lane,
   input  line_t                line_data,
   output line_t                word_rep,
   output mask_t                lane_mask,
   output logic [31:0]          lane_word
);

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      word_rep = '0;
      for (int i = 0; i < num_words; i++) begin
         word_rep[32*i +: 32] = word_data;
      end
      lane_mask = mask_t'(byte_enable) << {lane, 2'b00};
      lane_word = 32'(line_data >> {lane, 5'b00000});
   end

endmodule

// File: rtl/line_write_combiner.sv
// One-line write-combining buffer between the 32-bit CPU port and the line port.
// Define WCB_FORWARD_EN to let fully-buffered word reads complete from the buffer.
module line_write_combiner
   import wcb_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_address,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [3:0]  mem_byte_enable,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_resp,
   input  logic        flush,
   output logic        flush_ack,
   output logic [31:0] line_address,
   output logic        line_read,
   output logic        line_write,
   output line_t       line_wdata,
   output mask_t       line_byte_enable,
   input  line_t       line_rdata,
   input  logic        line_resp,
   output logic        buf_valid
);

   state_t               state;
   logic [tag_bits-1:0]  tag;
   line_t                buf_data;
   mask_t                buf_mask;

   logic [tag_bits-1:0]  req_tag;
   logic [lane_bits-1:0] req_lane;
   logic                 hit;
   logic                 accept;
   logic                 need_flush;
   logic                 fwd_ok;
   logic                 addr_unused;

   line_t                sel_line;
   line_t                word_rep;
   mask_t                lane_mask;
   logic [31:0]          lane_word;
   line_t                bit_mask;

   assign req_tag     = mem_address[31:s_offset];
   assign req_lane    = mem_address[s_offset-1:2];
   assign addr_unused = ^mem_address[1:0];
   assign buf_valid   = |buf_mask;
   assign hit         = buf_valid && (tag == req_tag);

   // The lane mux reads the downstream line while a read is outstanding,
   // otherwise the buffer (for forwarding).
   assign sel_line = (state == READ) ? line_rdata : buf_data;

   word_lane_mux u_lane_mux (
      .word_data   (mem_wdata),
      .byte_enable (mem_byte_enable),
      .lane        (req_lane),
      .line_data   (sel_line),
      .word_rep    (word_rep),
      .lane_mask   (lane_mask),
      .lane_word   (lane_word)
   );

   assign bit_mask = expand_mask(lane_mask);

`ifdef WCB_FORWARD_EN
   mask_t lane_valid;
   assign lane_valid = buf_mask >> {req_lane, 2'b00};
   assign fwd_ok     = hit && (&lane_valid[3:0]);
`else
   assign fwd_ok     = 1'b0;
`endif

   // A request visible in its own completion cycle must not be taken twice.
   always_comb begin
      accept     = (state == IDLE) && !mem_resp && !flush_ack;
      need_flush = 1'b0;
      if (flush) begin
         need_flush = buf_valid;
      end else if (mem_write) begin
         need_flush = buf_valid && !hit;
      end else if (mem_read) begin
         need_flush = hit && !fwd_ok;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         // NOTE: the buffer is plain registers, so it is cleared on reset like any other state.
         tag              <= '0;
         buf_data         <= '0;
         buf_mask         <= '0;
         mem_rdata        <= '0;
         mem_resp         <= 1'b0;
         flush_ack        <= 1'b0;
         line_address     <= '0;
         line_read        <= 1'b0;
         line_write       <= 1'b0;
         line_wdata       <= '0;
         line_byte_enable <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from pre-edge values.
         mem_resp  <= 1'b0;
         flush_ack <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  if (need_flush) begin
                     state            <= FLUSH;
                     line_write       <= 1'b1;
                     line_address     <= {tag, {s_offset{1'b0}}};
                     line_wdata       <= buf_data;
                     line_byte_enable <= buf_mask;
                  end else if (flush) begin
                     flush_ack <= 1'b1;
                  end else if (mem_write) begin
                     buf_data <= (buf_data & ~bit_mask) | (word_rep & bit_mask);
                     buf_mask <= buf_mask | lane_mask;
                     tag      <= req_tag;
                     mem_resp <= 1'b1;
                  end else if (mem_read && fwd_ok) begin
                     mem_rdata <= lane_word;
                     mem_resp  <= 1'b1;
                  end else if (mem_read) begin
                     state        <= READ;
                     line_read    <= 1'b1;
                     line_address <= line_of(mem_address);
                  end
               end
            end
            FLUSH: begin
               if (line_resp) begin
                  state      <= IDLE;
                  line_write <= 1'b0;
                  tag        <= '0;
                  buf_data   <= '0;
                  buf_mask   <= '0;
               end
            end
            READ: begin
               if (line_resp) begin
                  state     <= IDLE;
                  line_read <= 1'b0;
                  mem_rdata <= lane_word;
                  mem_resp  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_line_write_combiner.sv
// Directed bench for line_write_combiner: a scoreboard of expected CPU responses
// plus an inline downstream responder; honours WCB_FORWARD_EN.
module tb_line_write_combiner;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  mem_address;
   logic         mem_read;
   logic         mem_write;
   logic [3:0]   mem_byte_enable;
   logic [31:0]  mem_wdata;
   logic [31:0]  mem_rdata;
   logic         mem_resp;
   logic         flush;
   logic         flush_ack;
   logic [31:0]  line_address;
   logic         line_read;
   logic         line_write;
   logic [255:0] line_wdata;
   logic [31:0]  line_byte_enable;
   logic [255:0] line_rdata;
   logic         line_resp;
   logic         buf_valid;

   typedef struct {
      logic        is_read;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   line_write_combiner dut (
      .clk              (clk),
      .rst              (rst),
      .mem_address      (mem_address),
      .mem_read         (mem_read),
      .mem_write        (mem_write),
      .mem_byte_enable  (mem_byte_enable),
      .mem_wdata        (mem_wdata),
      .mem_rdata        (mem_rdata),
      .mem_resp         (mem_resp),
      .flush            (flush),
      .flush_ack        (flush_ack),
      .line_address     (line_address),
      .line_read        (line_read),
      .line_write       (line_write),
      .line_wdata       (line_wdata),
      .line_byte_enable (line_byte_enable),
      .line_rdata       (line_rdata),
      .line_resp        (line_resp),
      .buf_valid        (buf_valid)
   );

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_write(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
      exp_t e;
      mem_address     = addr;
      mem_byte_enable = be;
      mem_wdata       = data;
      mem_write       = 1'b1;
      e.is_read = 1'b0;
      e.data    = '0;
      sb.push_back(e);
   endtask

   task automatic cpu_read(input logic [31:0] addr, input logic [31:0] exp_data);
      exp_t e;
      mem_address = addr;
      mem_read    = 1'b1;
      e.is_read = 1'b1;
      e.data    = exp_data;
      sb.push_back(e);
   endtask

   // exp_lat < 0 skips the latency check.
   task automatic wait_resp(input string tag, input int exp_lat);
      int   lat = 0;
      exp_t e;
      while (!mem_resp && lat < 20) begin
         step();
         lat++;
      end
      check({tag, "_resp"}, mem_resp, 1'b1);
      if (exp_lat >= 0) check({tag, "_lat"}, lat, exp_lat);
      if (mem_resp && sb.size() > 0) begin
         e = sb.pop_front();
         if (e.is_read) check({tag, "_rdata"}, mem_rdata, e.data);
      end
      mem_read  = 1'b0;
      mem_write = 1'b0;
      step();
   endtask

   task automatic wait_flush_ack(input string tag);
      int n = 0;
      while (!flush_ack && n < 20) begin
         step();
         n++;
      end
      check({tag, "_ack"}, flush_ack, 1'b1);
      check({tag, "_no_resp"}, mem_resp, 1'b0);
      flush = 1'b0;
      step();
   endtask

   task automatic serve_line(input string tag, input logic is_write, input logic [31:0] addr,
                             input logic [31:0] mask, input logic [255:0] wdata,
                             input logic [255:0] rdata);
      int n = 0;
      while (!(line_write || line_read) && n < 20) begin
         step();
         n++;
      end
      check({tag, "_req"}, line_write || line_read, 1'b1);
      check({tag, "_kind"}, {line_write, line_read}, {is_write, !is_write});
      check({tag, "_addr"}, line_address, addr);
      if (is_write) begin
         check({tag, "_mask"}, line_byte_enable, mask);
         check({tag, "_wdata"}, line_wdata, wdata);
      end
      step();
      step();
      check({tag, "_stable"}, {line_write, line_read, line_address, mem_resp},
            {is_write, !is_write, addr, 1'b0});
      line_rdata = rdata;
      line_resp  = 1'b1;
      step();
      line_resp  = 1'b0;
      check({tag, "_drop"}, {line_write, line_read}, 2'b00);
   endtask

   initial begin
      rst             = 1'b1;
      mem_address     = '0;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_byte_enable = '0;
      mem_wdata       = '0;
      flush           = 1'b0;
      line_rdata      = '0;
      line_resp       = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      step();
      check("reset_outs", {mem_rdata, mem_resp, flush_ack, line_address, line_read, line_write,
                           line_byte_enable, buf_valid}, '0);
      check("reset_wdata", line_wdata, '0);

      // Two merging stores into line 0x100.
      cpu_write(32'h100, 4'hF, 32'h11223344);
      wait_resp("wr0", 1);
      cpu_write(32'h104, 4'h1, 32'h000000AA);
      wait_resp("wr1", 1);
      check("merge_no_lw", line_write, 1'b0);
      check("merge_valid", buf_valid, 1'b1);

      // Write miss drains the partial line, then the store is absorbed.
      cpu_write(32'h200, 4'hF, 32'h55667788);
      serve_line("miss", 1'b1, 32'h100, 32'h0000001F, 256'h000000AA_11223344, '0);
      wait_resp("miss_wr", 1);
      check("miss_valid", buf_valid, 1'b1);

      // Explicit drain of a valid buffer.
      flush = 1'b1;
      serve_line("fl", 1'b1, 32'h200, 32'h0000000F, 256'h55667788, '0);
      wait_flush_ack("fl");
      check("fl_empty", buf_valid, 1'b0);

      // Read miss with an empty buffer: lane 1 of the returned line.
      cpu_read(32'h304, 32'hDEADBEEF);
      serve_line("rd", 1'b0, 32'h300, '0, '0, {192'h0, 32'hDEADBEEF, 32'h01020304});
      wait_resp("rd", 0);

      // Read of the buffered line.
      cpu_write(32'h100, 4'hF, 32'h11223344);
      wait_resp("wr2", 1);
      cpu_read(32'h100, 32'h11223344);
`ifdef WCB_FORWARD_EN
      wait_resp("fwd", 1);
      check("fwd_no_line", {line_read, line_write}, 2'b00);
      check("fwd_keep", buf_valid, 1'b1);
      flush = 1'b1;
      serve_line("fwd_fl", 1'b1, 32'h100, 32'h0000000F, 256'h11223344, '0);
      wait_flush_ack("fwd_fl");
`else
      serve_line("hit_fl", 1'b1, 32'h100, 32'h0000000F, 256'h11223344, '0);
      serve_line("hit_rd", 1'b0, 32'h100, '0, '0, {224'h0, 32'h11223344});
      wait_resp("hit_rd", 0);
`endif
      check("hit_empty", buf_valid, 1'b0);

      // Flush and store together: the drain wins, then the sub-word store lands.
      cpu_write(32'h140, 4'hF, 32'hCAFEF00D);
      wait_resp("wr3", 1);
      cpu_write(32'h144, 4'hC, 32'h12345678);
      flush = 1'b1;
      serve_line("race", 1'b1, 32'h140, 32'h0000000F, 256'hCAFEF00D, '0);
      wait_flush_ack("race");
      wait_resp("race_wr", 1);
      flush = 1'b1;
      serve_line("sub", 1'b1, 32'h140, 32'h000000C0, 256'h12340000_00000000, '0);
      wait_flush_ack("sub");

      // Empty-buffer flush acknowledges on the next cycle.
      flush = 1'b1;
      step();
      check("empty_fl_ack", flush_ack, 1'b1);
      flush = 1'b0;
      step();

      // Stray line_resp in IDLE is ignored.
      line_resp = 1'b1;
      step();
      line_resp = 1'b0;
      check("stray_resp", {line_read, line_write, mem_resp, flush_ack, buf_valid}, '0);

      // Reset in the middle of a drain.
      cpu_write(32'h180, 4'hF, 32'h0BADF00D);
      wait_resp("wr4", 1);
      cpu_write(32'h1A0, 4'hF, 32'h600DCAFE);
      step();
      check("rst_fl_lw", line_write, 1'b1);
      rst       = 1'b1;
      mem_write = 1'b0;
      step();
      check("rst_outs", {mem_rdata, mem_resp, flush_ack, line_address, line_read, line_write,
                         line_byte_enable, buf_valid}, '0);
      check("rst_wdata", line_wdata, '0);
      rst = 1'b0;
      sb.delete();
      step();
      flush = 1'b1;
      step();
      check("rst_idle_ack", {flush_ack, line_write}, 2'b10);
      flush = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/line_write_combiner.md
Name: line_write_combiner

Overview:
- Sequential successor to the word/line lane adapter; sits between the CPU-side 32-bit data port and the line-wide cache/arbiter port.
- Merges word and sub-word stores to the same line into a one-line write-combining buffer with per-byte valid bits.
- Flushes the buffer downstream as one masked line write; performs word reads as line reads with lane select.

Parameters:
- s_offset, 5, line offset bits; line = 2**s_offset bytes.
- s_mask, 2**s_offset, bytes per line and line byte-enable width.
- s_line, 8*s_mask, line data width in bits.
- num_words, s_line/32, 32-bit lanes per line.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_address  in  32  CPU byte address
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_byte_enable  in  4  CPU write byte mask
- mem_wdata  in  32  CPU write data
- mem_rdata  out  32  CPU read data, valid with mem_resp
- mem_resp  out  1  one-cycle completion pulse
- flush  in  1  drain request, held until flush_ack
- flush_ack  out  1  one-cycle drain-complete pulse
- line_address  out  32  line address, offset bits forced to 0
- line_read  out  1  downstream line read, held until line_resp
- line_write  out  1  downstream line write, held until line_resp
- line_wdata  out  s_line  buffered line data
- line_byte_enable  out  s_mask  buffered byte-valid mask
- line_rdata  in  s_line  downstream read data
- line_resp  in  1  downstream completion
- buf_valid  out  1  buffer holds at least one valid byte

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: state IDLE; all outputs 0; buffer tag, data and byte-valid mask cleared.
- States: IDLE, FLUSH, READ.
- Request sampling: only in IDLE with mem_resp=0. A request still visible during its own mem_resp cycle is not re-accepted.
- Write hit or empty buffer (IDLE):
  - Merge the enabled bytes into lane mem_address[s_offset-1:2]; set their valid bits; load the tag.
  - mem_resp=1 next cycle; write latency 1.
- Write miss (buffer valid, tag differs):
  - IDLE->FLUSH.
  - On line_resp: clear the buffer, return to IDLE; the held write is then accepted as an empty-buffer write.
- Read, line matches buffer (feature off): FLUSH first, then READ.
- Read, no match: IDLE->READ with line_read=1 and line_address = line of mem_address.
  - On line_resp: register the 32-bit lane mem_address[s_offset-1:2] into mem_rdata, pulse mem_resp, go to IDLE.
- FLUSH:
  - line_write=1; line_address = {tag, zeros}; line_wdata and line_byte_enable come from the buffer.
  - Outputs are stable until line_resp.
- flush input:
  - In IDLE with a valid buffer: FLUSH, then flush_ack pulse.
  - In IDLE with an empty buffer: flush_ack the next cycle.
- Simultaneous flush and CPU request in IDLE: flush wins; the request waits.
- line_resp outside FLUSH/READ is ignored.
- line_read and line_write are never both 1.
- Partial-line flush is legal; bytes with enable 0 are never written downstream.
- Reset mid-FLUSH or mid-READ: the transaction is abandoned and buffer contents are lost.

Optional Feature:
- Macro WCB_FORWARD_EN.
- Defined: a read that matches the buffered line, with all 4 requested bytes valid, completes from the buffer. mem_rdata = buffered lane, mem_resp next cycle, no downstream access. A match with any requested byte invalid behaves as the feature-off case.
- Undefined: every matching read flushes first.

Decomposition:
- Package wcb_pkg:
  - state enum {IDLE, FLUSH, READ};
  - typedefs line_t [s_line-1:0] and mask_t [s_mask-1:0];
  - function line_of(addr) clearing the offset bits.
- One sub-module, word_lane_mux (combinational):
  - replicates 32-bit data across num_words lanes;
  - shifts a 4-bit enable to lane position;
  - selects a 32-bit lane from a line.

Test Plan:
- Write 0x11223344 mask 4'hF to 0x100, then mask 4'h1 data 0xAA to 0x104 -> two mem_resp after 1 cycle each; no line_write; buf_valid=1.
- Then write to 0x200 -> line_write with line_address 0x100, line_byte_enable 0x0000001F, line_wdata bytes 0..3 = 44,33,22,11 and byte 4 = AA; after line_resp, the write is absorbed.
- Read 0x304, buffer empty, line_rdata lane1 = 0xDEADBEEF -> line_read, then mem_rdata 0xDEADBEEF with mem_resp one cycle after line_resp.
- Read 0x100 with the buffered line 0x100: without WCB_FORWARD_EN -> flush then read; with it -> mem_rdata 0x11223344 next cycle, no line_read.
- flush held together with mem_write in IDLE -> FLUSH first, flush_ack pulse, then the write is accepted.
- Assert rst during FLUSH with line_resp withheld -> next cycle all outputs 0, buf_valid=0, state IDLE.
